// File: rtl/mem_copy_master.sv
// ============================================================================
// Module      : mem_copy_master
// Description : Bus-initiator word copy engine. Copies len consecutive words
//               from src_addr to dst_addr over the shared command bus using a
//               request/grant handshake; read, then write, one word at a time.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_copy_master #(
    parameter int AW = 9,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] src_addr,
    input  logic [AW-1:0] dst_addr,
    input  logic [AW-1:0] len,
    input  logic          bus_gnt,
    input  logic [DW-1:0] read_data,
    output logic          bus_req,
    output logic [1:0]    mem_cmd,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] write_data,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] words_done
);

    localparam logic [1:0] c_CMD_NONE  = 2'b00;
    localparam logic [1:0] c_CMD_READ  = 2'b01;
    localparam logic [1:0] c_CMD_WRITE = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_RD1  = 3'd2,
        S_RD2  = 3'd3,
        S_WR   = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [AW-1:0] r_cur_src;
    logic [AW-1:0] r_cur_dst;
    logic [AW-1:0] r_len;
    logic [AW-1:0] r_words_done;
    logic [AW-1:0] w_src_nxt;
    logic [AW-1:0] w_dst_nxt;
    logic [AW-1:0] w_len_nxt;
    logic [AW-1:0] w_words_nxt;
    logic [AW-1:0] w_words_inc;

    // Output registers; their next values are decoded from the next state so
    // every output is a flop and matches the state it describes.
    logic          r_bus_req;
    logic [1:0]    r_mem_cmd;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_write_data;
    logic          r_busy;
    logic          r_done;
    logic          w_bus_req_nxt;
    logic [1:0]    w_mem_cmd_nxt;
    logic [AW-1:0] w_mem_addr_nxt;
    logic [DW-1:0] w_write_data_nxt;
    logic          w_busy_nxt;
    logic          w_done_nxt;

    assign w_words_inc = r_words_done + AW'(1);

    // Next-state, transfer counters and next output values.
    always_comb begin
        w_state_nxt      = r_state;
        w_src_nxt        = r_cur_src;
        w_dst_nxt        = r_cur_dst;
        w_len_nxt        = r_len;
        w_words_nxt      = r_words_done;
        w_write_data_nxt = r_write_data;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_src_nxt   = src_addr;
                    w_dst_nxt   = dst_addr;
                    w_len_nxt   = len;
                    w_words_nxt = '0;
                    w_state_nxt = (len == '0) ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                if (bus_gnt) begin
                    w_state_nxt = S_RD1;
                end
            end
            S_RD1: begin
                w_state_nxt = bus_gnt ? S_RD2 : S_REQ;
            end
            S_RD2: begin
                // Registered RAM data is valid in this phase; capture only if
                // the word is going to be written, so write_data stays put
                // when the grant is lost.
                if (bus_gnt) begin
                    w_write_data_nxt = read_data;
                    w_state_nxt      = S_WR;
                end else begin
                    w_state_nxt = S_REQ;
                end
            end
            S_WR: begin
                if (bus_gnt) begin
                    w_src_nxt   = r_cur_src + AW'(1);
                    w_dst_nxt   = r_cur_dst + AW'(1);
                    w_words_nxt = w_words_inc;
                    w_state_nxt = (w_words_inc == r_len) ? S_DONE : S_RD1;
                end else begin
                    w_state_nxt = S_REQ;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_bus_req_nxt  = 1'b0;
        w_busy_nxt     = 1'b0;
        w_done_nxt     = 1'b0;
        w_mem_cmd_nxt  = c_CMD_NONE;
        w_mem_addr_nxt = r_mem_addr;

        case (w_state_nxt)
            S_REQ: begin
                w_bus_req_nxt = 1'b1;
                w_busy_nxt    = 1'b1;
            end
            S_RD1: begin
                w_bus_req_nxt  = 1'b1;
                w_busy_nxt     = 1'b1;
                w_mem_cmd_nxt  = c_CMD_READ;
                w_mem_addr_nxt = w_src_nxt;
            end
            S_RD2: begin
                w_bus_req_nxt = 1'b1;
                w_busy_nxt    = 1'b1;
                w_mem_cmd_nxt = c_CMD_READ;
            end
            S_WR: begin
                w_bus_req_nxt  = 1'b1;
                w_busy_nxt     = 1'b1;
                w_mem_cmd_nxt  = c_CMD_WRITE;
                w_mem_addr_nxt = w_dst_nxt;
            end
            S_DONE: begin
                w_done_nxt = 1'b1;
            end
            default: begin
                w_done_nxt = 1'b0;
            end
        endcase
    end

    // State, counters and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_cur_src    <= '0;
            r_cur_dst    <= '0;
            r_len        <= '0;
            r_words_done <= '0;
            r_bus_req    <= 1'b0;
            r_mem_cmd    <= c_CMD_NONE;
            r_mem_addr   <= '0;
            r_write_data <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cur_src    <= w_src_nxt;
            r_cur_dst    <= w_dst_nxt;
            r_len        <= w_len_nxt;
            r_words_done <= w_words_nxt;
            r_bus_req    <= w_bus_req_nxt;
            r_mem_cmd    <= w_mem_cmd_nxt;
            r_mem_addr   <= w_mem_addr_nxt;
            r_write_data <= w_write_data_nxt;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
        end
    end

    assign bus_req    = r_bus_req;
    assign mem_cmd    = r_mem_cmd;
    assign mem_addr   = r_mem_addr;
    assign write_data = r_write_data;
    assign busy       = r_busy;
    assign done       = r_done;
    assign words_done = r_words_done;

endmodule

`default_nettype wire

// File: tb/tb_mem_copy_master.sv
// ============================================================================
// Module      : tb_mem_copy_master
// Description : Scoreboard bench for mem_copy_master with a RAM/I/O responder
//               and a forward-copy reference model of the address space.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_copy_master;

    logic        clk;
    logic        reset;
    logic        start;
    logic [8:0]  src_addr;
    logic [8:0]  dst_addr;
    logic [8:0]  len;
    logic        bus_gnt;
    logic [15:0] read_data;
    logic        bus_req;
    logic [1:0]  mem_cmd;
    logic [8:0]  mem_addr;
    logic [15:0] write_data;
    logic        busy;
    logic        done;
    logic [8:0]  words_done;

    mem_copy_master #(.AW(9), .DW(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .len        (len),
        .bus_gnt    (bus_gnt),
        .read_data  (read_data),
        .bus_req    (bus_req),
        .mem_cmd    (mem_cmd),
        .mem_addr   (mem_addr),
        .write_data (write_data),
        .busy       (busy),
        .done       (done),
        .words_done (words_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Responder state: 256-word RAM with registered output, switches, LEDs.
    logic [15:0] ram [256];
    logic [15:0] ram_q;
    logic [7:0]  sw;
    logic [7:0]  led;

    assign read_data = (mem_cmd == 2'b01) ?
                       (mem_addr[8] ? ((mem_addr == 9'h140) ? {8'h00, sw} : 16'h0000) : ram_q) :
                       16'h0000;

    // Reference model of the address space.
    logic [15:0] model_ram [256];
    logic [7:0]  model_led;

    typedef struct packed {
        logic [8:0]  a;
        logic [15:0] d;
    } wr_t;

    wr_t exp_wr[$];
    int  exp_done[$];
    int  total;
    int  bad;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] model_read(input logic [8:0] a);
        if (!a[8]) return model_ram[a[7:0]];
        if (a == 9'h140) return {8'h00, sw};
        return 16'h0000;
    endfunction

    // Forward copy on the model, queueing each expected bus write in order.
    task automatic prep(input logic [8:0] s, input logic [8:0] d, input logic [8:0] n);
        logic [8:0]  as;
        logic [8:0]  ad;
        logic [15:0] v;
        model_ram = ram;
        model_led = led;
        for (int i = 0; i < int'(n); i++) begin
            as = s + 9'(i);
            ad = d + 9'(i);
            v  = model_read(as);
            if (!ad[8]) model_ram[ad[7:0]] = v;
            else if (ad == 9'h100) model_led = v[7:0];
            exp_wr.push_back('{a: ad, d: v});
        end
        exp_done.push_back(int'(n));
    endtask

    task automatic responder();
        forever begin
            @(posedge clk);
            ram_q <= ram[mem_addr[7:0]];
            if (mem_cmd == 2'b10 && bus_gnt) begin
                if (!mem_addr[8]) ram[mem_addr[7:0]] <= write_data;
                else if (mem_addr == 9'h100) led <= write_data[7:0];
            end
        end
    endtask

    task automatic monitor();
        wr_t e;
        int  n;
        forever begin
            @(negedge clk);
            if (mem_cmd == 2'b10 && bus_gnt) begin
                if (exp_wr.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write: addr %0h data %0h, expected none", mem_addr, write_data);
                end else begin
                    e = exp_wr.pop_front();
                    chk("write_addr_data", {7'b0, mem_addr, write_data}, {7'b0, e.a, e.d});
                end
            end
            if (done) begin
                if (exp_done.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: words_done %0d, expected no done", words_done);
                end else begin
                    n = exp_done.pop_front();
                    chk("done_words", 32'(words_done), 32'(n));
                end
            end
        end
    endtask

    // gmode: 0 grant held, 1 random grant, 2 grant dropped for two cycles in RD2 of word 1.
    task automatic run_copy(input logic [8:0] s, input logic [8:0] d, input logic [8:0] n,
                            input int gmode, input int exp_lat);
        int cyc;
        int busy_cnt;
        int cmdnz;
        int lim;
        int mism;
        prep(s, d, n);
        src_addr = s;
        dst_addr = d;
        len      = n;
        start    = 1'b1;
        bus_gnt  = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        cyc      = 0;
        busy_cnt = int'(busy);
        cmdnz    = int'(mem_cmd != 2'b00);
        lim      = 24 * int'(n) + 50;
        while (!done && cyc < lim) begin
            case (gmode)
                1:       bus_gnt = ($urandom_range(0, 3) != 0);
                2:       bus_gnt = !(cyc == 2 || cyc == 3);
                default: bus_gnt = 1'b1;
            endcase
            @(posedge clk);
            #1;
            cyc++;
            busy_cnt += int'(busy);
            cmdnz    += int'(mem_cmd != 2'b00);
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL done_timeout: no done after %0d cycles, expected done", cyc);
        end
        if (exp_lat >= 0) begin
            chk("done_latency", 32'(cyc), 32'(exp_lat));
            chk("busy_cycles", 32'(busy_cnt), 32'(exp_lat));
        end
        if (n == 9'd0) chk("zero_len_cmd_idle", 32'(cmdnz), 32'd0);
        bus_gnt = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_after_done", {30'b0, busy, done}, 32'd0);
        chk("words_done_hold", 32'(words_done), 32'(n));
        mism = 0;
        for (int i = 0; i < 256; i++) begin
            if (ram[i] !== model_ram[i]) mism++;
        end
        chk("ram_image_mismatches", 32'(mism), 32'd0);
        chk("led_value", 32'(led), 32'(model_led));
        chk("pending_writes", 32'(exp_wr.size()), 32'd0);
    endtask

    task automatic driver();
        logic [8:0] rs;
        logic [8:0] rd;
        logic [8:0] rn;
        for (int i = 0; i < 256; i++) ram[i] = 16'($urandom);
        sw       = 8'h5A;
        led      = 8'h00;
        reset    = 1'b0;
        start    = 1'b0;
        src_addr = '0;
        dst_addr = '0;
        len      = '0;
        bus_gnt  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_cmd_req_busy_done", {28'b0, mem_cmd, bus_req, busy}, 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_addr_words", {14'b0, mem_addr, words_done}, 32'd0);
        chk("reset_write_data", 32'(write_data), 32'd0);
        reset = 1'b1;

        // Basic copy of four known words.
        for (int i = 0; i < 4; i++) ram[16 + i] = 16'hA001 + 16'(i);
        run_copy(9'h010, 9'h040, 9'd4, 0, 13);
        chk("basic_dst_word3", 32'(ram[8'h43]), 32'hA004);

        run_copy(9'h020, 9'h030, 9'd0, 0, 0);
        run_copy(9'h050, 9'h060, 9'd3, 2, 14);
        run_copy(9'h0FE, 9'h0F0, 9'd3, 0, 10);
        run_copy(9'h1FF, 9'h020, 9'd2, 0, 7);
        run_copy(9'h140, 9'h100, 9'd1, 0, 4);
        chk("io_led", 32'(led), 32'h5A);
        run_copy(9'h030, 9'h032, 9'd6, 0, 19);

        // Reset in the read data phase of word 2 of a four-word copy.
        prep(9'h070, 9'h0A0, 9'd4);
        src_addr = 9'h070;
        dst_addr = 9'h0A0;
        len      = 9'd4;
        start    = 1'b1;
        bus_gnt  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_cmd_req_busy", {29'b0, mem_cmd, bus_req} | {31'b0, busy}, 32'd0);
        chk("midrst_addr_words", {14'b0, mem_addr, words_done}, 32'd0);
        reset = 1'b1;
        exp_wr.delete();
        exp_done.delete();
        @(posedge clk);
        #1;
        chk("midrst_stays_idle", {30'b0, busy, done}, 32'd0);
        run_copy(9'h070, 9'h0A0, 9'd4, 0, 13);

        run_copy(9'h000, 9'h003, 9'd511, 0, 1534);

        for (int t = 0; t < 4; t++) begin
            rs = 9'($urandom);
            rd = 9'($urandom);
            rn = 9'($urandom_range(1, 20));
            run_copy(rs, rd, rn, 0, 3 * int'(rn) + 1);
        end
        for (int t = 0; t < 10; t++) begin
            rs = 9'($urandom);
            rd = 9'($urandom);
            rn = 9'($urandom_range(0, 24));
            run_copy(rs, rd, rn, 1, -1);
        end
        repeat (2) @(posedge clk);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        fork
            responder();
            monitor();
            driver();
        join_any
        disable fork;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_copy_master.md
# mem_copy_master

Bus-initiator copy engine for the lab 8 memory system. Issues `mem_cmd`/`mem_addr`/`write_data` on the same command bus the CPU drives, and consumes `read_data` from the RAM/I/O responder. Copies `len` consecutive 16-bit words from `src_addr` to `dst_addr`, word by word, under a request/grant handshake with the top-level bus mux. Targets are RAM (`addr[8]=0`) or memory-mapped I/O (switches at `0x140`, LEDs at `0x100`).

## Interface
- `AW`, 9: address width; addresses wrap modulo 2^AW.
- `DW`, 16: data width.
- `clk`  in  1  clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-low; `reset==0` at a posedge resets the block.
- `start`  in  1  sampled only in IDLE; launches a transfer.
- `src_addr`  in  AW  first source address; captured with `start`.
- `dst_addr`  in  AW  first destination address; captured with `start`.
- `len`  in  AW  word count, 0..511; captured with `start`.
- `bus_gnt`  in  1  bus granted to this block; top mux routes our `mem_cmd`/`mem_addr`/`write_data` when high.
- `read_data`  in  DW  responder read data.
- `bus_req`  out  1  bus request.
- `mem_cmd`  out  2  `00` none, `01` MREAD, `10` MWRITE.
- `mem_addr`  out  AW  bus address.
- `write_data`  out  DW  write data.
- `busy`  out  1  transfer in progress.
- `done`  out  1  one-cycle completion pulse.
- `words_done`  out  AW  words completed in the current/last transfer.

## Operation
- States: IDLE, REQ, RD1, RD2, WR, DONE. All outputs are registered.
- Reset: IDLE. `mem_cmd=00`, `mem_addr=0`, `write_data=0`, `bus_req=0`, `busy=0`, `done=0`, `words_done=0`.
- IDLE: on `start=1`, capture src/dst/len and clear `words_done`. If `len==0`, go to DONE. Otherwise go to REQ.
- REQ: `bus_req=1`, `busy=1`, `mem_cmd=00`. If `bus_gnt=1`, go to RD1.
- RD1 (address phase): `mem_cmd=01`, `mem_addr=cur_src`. Go to RD2.
- RD2 (data phase): `mem_cmd=01` and address held, because the RAM output is registered and the responder gates `read_data` on MREAD. Capture `read_data` into the data register at the closing edge. Go to WR.
- WR: `mem_cmd=10`, `mem_addr=cur_dst`, `write_data`=captured word. At the closing edge: increment `cur_src`, `cur_dst` and `words_done`, with address wrap mod 512. If `words_done+1==len`, go to DONE; else go to RD1.
- DONE: `done=1`, `busy=0`, `bus_req=0`, `mem_cmd=00`. Go to IDLE.
- `start` outside IDLE is ignored.
- Grant loss: if `bus_gnt=0` is sampled at the closing edge of RD1, RD2 or WR, the current word is abandoned and the block goes to REQ with `mem_cmd=00`. That word is redone from RD1. Counters are not advanced.
- `bus_req` stays high for the whole transfer (REQ through WR).
- `write_data` holds its last value outside WR.
- Overlap: the copy is forward, ascending. If ranges overlap with `dst>src`, the result is that of a forward copy, and this is the intended behaviour.

## Timing
- E0 is the edge at which `start` is sampled in IDLE.
- With `bus_gnt` held high, the block is in RD1 after E1.
- Each word takes 3 cycles: RD1, RD2, WR.
- Last WR closes at edge E(1+3N). DONE is the cycle after E(1+3N). IDLE follows after E(2+3N).
- `len==0`: DONE is the cycle after E0, with no nonzero `mem_cmd`.
- Wrap: address `0x1FF` + 1 becomes `0x000`. `len=511` with `words_done` at 9 bits must terminate correctly.
- Reset mid-transfer: at the first posedge with `reset==0`, all outputs take reset values. Any partial write in progress is not retried.
- A new `start` is accepted in the IDLE cycle directly after DONE.

## Test plan
- Basic copy: RAM[0x10..0x13] = 0xA001..0xA004, `bus_gnt=1`, `start` with src=0x10, dst=0x40, len=4 -> `done` in the cycle after E13; RAM[0x40..0x43] = 0xA001..0xA004; `words_done=4`; `busy` high exactly cycles E0..E13.
- Zero length: `start` with len=0 -> `done` in the cycle after E0; `mem_cmd` stays `00` throughout.
- Grant loss: len=3, drop `bus_gnt` for 2 cycles during RD2 of word 1 -> word 1 is re-read from RD1; final destination correct; `done` delayed by exactly re-grant cycles + 2.
- Wrap: src=0x0FE, dst=0x0F0, len=3 (RAM) -> reads 0x0FE, 0x0FF, 0x100. Also run src=0x1FF, len=2 -> read addresses 0x1FF, 0x000.
- I/O path: SW[7:0]=0x5A, src=0x140, dst=0x100, len=1 -> LEDR[7:0]=0x5A after WR.
- Reset mid-transfer: assert `reset=0` during word 2 of a len=4 copy -> next cycle `mem_cmd=00`, `bus_req=0`, `busy=0`. A subsequent `start` then copies all words correctly.
